// File: rtl/pipe_vect_hs.sv
// Elastic pipeline stage carrying a scalar word plus NUM_VECT vector operands.
// A main register and a one-entry skid register give a registered in_ready and full throughput.
module pipe_vect_hs #(
  parameter int WIDTH        = 8,
  parameter int registerSize = 8,
  parameter int vectorSize   = 4,
  parameter int NUM_VECT     = 3
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     flush,
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic [WIDTH-1:0]                                         in,
  input  logic [NUM_VECT-1:0][vectorSize-1:0][registerSize-1:0]    vect_in,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [WIDTH-1:0]                                         out,
  output logic [NUM_VECT-1:0][vectorSize-1:0][registerSize-1:0]    vect_out,
  output logic [1:0]                                               level
);

  typedef logic [NUM_VECT-1:0][vectorSize-1:0][registerSize-1:0] vect_t;

  // Encoding doubles as the occupancy count reported on level.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_word, skid_word;
  vect_t            main_vect, skid_vect;
  logic             push, pop;
  logic             ld_main_in, ld_main_skid, ld_skid;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign level     = state;
  assign out       = main_word;
  assign vect_out  = main_vect;

  always_comb begin
    state_nx     = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          ld_main_in = 1'b1;
          state_nx   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          ld_main_in = 1'b1;
        end else if (push) begin
          ld_skid  = 1'b1;
          state_nx = FULL;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          ld_main_skid = 1'b1;
          state_nx     = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // Squash wins over everything; payloads are left untouched since they are don't-care when invalid.
    if (flush) begin
      state_nx     = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != FULL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_word <= '0;
      main_vect <= '0;
    end else if (ld_main_in) begin
      main_word <= in;
      main_vect <= vect_in;
    end else if (ld_main_skid) begin
      main_word <= skid_word;
      main_vect <= skid_vect;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_word <= '0;
      skid_vect <= '0;
    end else if (ld_skid) begin
      skid_word <= in;
      skid_vect <= vect_in;
    end
  end

endmodule

// File: tb/tb_pipe_vect_hs.sv
// Scoreboard bench for pipe_vect_hs: the driver queues expected words on accepted pushes,
// a monitor pops and compares on every output handshake.
module tb_pipe_vect_hs;
  localparam int W = 8;
  localparam int R = 8;
  localparam int V = 4;
  localparam int N = 3;

  typedef logic [N-1:0][V-1:0][R-1:0] vect_t;
  typedef struct packed {
    logic [W-1:0] s;
    vect_t        v;
  } item_t;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din;
  vect_t        vin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  vect_t        vout;
  logic [1:0]   level;

  int    checks = 0;
  int    errors = 0;
  item_t exp_q[$];

  pipe_vect_hs #(.WIDTH(W), .registerSize(R), .vectorSize(V), .NUM_VECT(N)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in(din), .vect_in(vin),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout), .vect_out(vout),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Lane j of operand k is {k,j} scrambled by the word index so every word differs.
  function automatic vect_t mkv(input logic [7:0] idx);
    vect_t v;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < V; j++)
        v[k][j] = {4'(k), 4'(j)} ^ idx;
    return v;
  endfunction

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send(input logic [7:0] idx);
    int guard;
    in_valid = 1'b1;
    din      = idx;
    vin      = mkv(idx);
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      if (!flush) exp_q.push_back('{s: idx, v: mkv(idx)});
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) @(negedge clk);
    chk("drain_empty", out_valid, 0);
  endtask

  // Sampled just before the rising edge, after all driver updates for the cycle.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        chk("out_valid_known", $isunknown(out_valid), 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", dout, e.s);
            chk("out_vect", vout, e.v);
          end
        end
        if (flush) exp_q.delete();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     idx;
    logic   acc;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; vin = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_out", dout, 0);
    chk("rst_vect_out", vout, 0);
    reset = 1'b1;
    @(negedge clk);

    // streaming: one word per cycle, level pinned at 1
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) begin
        chk("stream_level", level, 1);
        chk("stream_out", dout, 8'(i - 1));
      end
      send(8'(i));
    end
    // simultaneous push and pop at level 1
    send(8'h5a);
    chk("pushpop_level", level, 1);
    chk("pushpop_out", dout, 8'h5a);
    drain();

    // backpressure: A, B fill the stage, C must wait
    @(negedge clk);
    out_ready = 1'b0;
    send(8'hA0);
    send(8'hB0);
    chk("bp_level", level, 2);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b1; din = 8'hC0; vin = mkv(8'hC0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_out", dout, 8'hA0);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    send(8'hC0);
    drain();

    // flush at level 2 with an in-flight word
    @(negedge clk);
    out_ready = 1'b0;
    send(8'hE0);
    send(8'hF0);
    chk("fl_pre_level", level, 2);
    in_valid = 1'b1; din = 8'h77; vin = mkv(8'h77);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_level", level, 0);
    chk("fl_in_ready", in_ready, 1);
    send(8'h33);
    chk("fl_next_valid", out_valid, 1);
    chk("fl_next_out", dout, 8'h33);
    drain();

    // random valid/ready traffic
    @(negedge clk);
    idx = 100;
    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        din = 8'(idx);
        vin = mkv(8'(idx));
        idx++;
      end
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back('{s: din, v: vin});
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    drain();
    chk("rand_queue_empty", exp_q.size(), 0);

    // asynchronous reset while full
    @(negedge clk);
    out_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    chk("ar_pre_level", level, 2);
    #2 reset = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_level", level, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_vect_out", vout, 0);
    chk("ar_out", dout, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ar_after_level", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
